// File: rtl/kronos_mem_arbiter_pkg.sv
// Shared types and constants for the Kronos memory-port arbiter.
package kronos_mem_arbiter_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned TMR_W   = 16;

    // Arbiter FSM encoding
    typedef logic [1:0] arb_state_e;
    localparam arb_state_e ARB_IDLE  = 2'd0;
    localparam arb_state_e ARB_INSTR = 2'd1;
    localparam arb_state_e ARB_DATA  = 2'd2;

    // Fetches always read a full word
    localparam logic [MASK_W-1:0] FETCH_MASK = 4'hF;

endpackage

// File: rtl/kronos_mem_arb_timer.sv
// Watchdog counter for an outstanding bus transaction.
// Only instantiated when KRONOS_MEM_ARB_TIMEOUT_EN is defined.
module kronos_mem_arb_timer
    import kronos_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] cnt;

    // Count waiting cycles since the last grant, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != {TMR_W{1'b1}})) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th waiting cycle after the grant
    assign expire = enable && (cnt == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/kronos_mem_arbiter.sv
// Kronos memory arbiter: shares one req/ack bus port between instruction
// fetch and EX-stage load/store. Data has priority; a burst limit forces a
// pending fetch through after MAX_DATA_BURST consecutive data grants.
// Optional watchdog: define KRONOS_MEM_ARB_TIMEOUT_EN.
module kronos_mem_arbiter
    import kronos_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   instr_addr,
    input  logic              instr_req,
    output logic [XLEN-1:0]   instr_data,
    output logic              instr_ack,
    output logic              instr_err,
    input  logic [XLEN-1:0]   data_addr,
    input  logic [XLEN-1:0]   data_wr_data,
    input  logic [MASK_W-1:0] data_mask,
    input  logic              data_wr_en,
    input  logic              data_req,
    output logic [XLEN-1:0]   data_rd_data,
    output logic              data_ack,
    output logic              data_err,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wr_data,
    output logic [MASK_W-1:0] mem_mask,
    output logic              mem_wr_en,
    output logic              mem_req,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic              mem_ack
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

    if ((MAX_DATA_BURST < 1) || (MAX_DATA_BURST > 15) ||
        (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (2 ** TMR_W))) begin : g_param_chk
        $error("kronos_mem_arbiter: parameter out of range");
    end

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic               grant_data_c;
    logic               grant_instr_c;
    logic               done_c;
    logic               expire_c;
    logic               abort_c;
    logic [BURST_W-1:0] burst;

`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
    kronos_mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant_data_c | grant_instr_c),
        .enable ((state != ARB_IDLE) && !mem_ack),
        .expire (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // Watchdog abort only when the bus did not answer this cycle
    assign abort_c = expire_c && !mem_ack;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and completion detection
    always_comb begin
        state_nxt     = state;
        grant_data_c  = 1'b0;
        grant_instr_c = 1'b0;
        done_c        = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (data_req && !(instr_req && (burst == BURST_MAX))) begin
                    grant_data_c = 1'b1;
                    state_nxt    = ARB_DATA;
                end else if (instr_req) begin
                    grant_instr_c = 1'b1;
                    state_nxt     = ARB_INSTR;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (mem_ack || expire_c) begin
                    done_c    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Bus command registers: loaded on grant, held until completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_mask    <= '0;
            mem_wr_en   <= 1'b0;
            mem_req     <= 1'b0;
        end else if (grant_data_c) begin
            mem_addr    <= data_addr;
            mem_wr_data <= data_wr_data;
            mem_mask    <= data_mask;
            mem_wr_en   <= data_wr_en;
            mem_req     <= 1'b1;
        end else if (grant_instr_c) begin
            mem_addr    <= instr_addr;
            mem_wr_data <= '0;
            mem_mask    <= FETCH_MASK;
            mem_wr_en   <= 1'b0;
            mem_req     <= 1'b1;
        end else if (done_c) begin
            mem_wr_en   <= 1'b0;
            mem_req     <= 1'b0;
        end
    end

    // Consecutive data grants while a fetch waits; saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst <= '0;
        end else if (grant_instr_c) begin
            burst <= '0;
        end else if (grant_data_c) begin
            if (!instr_req) begin
                burst <= '0;
            end else if (burst != BURST_MAX) begin
                burst <= burst + BURST_W'(1);
            end
        end
    end

    // Owner responses are combinational in the completing cycle
    assign instr_ack    = (state == ARB_INSTR) && done_c;
    assign data_ack     = (state == ARB_DATA)  && done_c;
    assign instr_err    = (state == ARB_INSTR) && abort_c;
    assign data_err     = (state == ARB_DATA)  && abort_c;
    assign instr_data   = ((state == ARB_INSTR) && !abort_c) ? mem_rd_data : '0;
    assign data_rd_data = ((state == ARB_DATA)  && !abort_c) ? mem_rd_data : '0;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed self-checking bench for kronos_mem_arbiter.
module tb_kronos_mem_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic        data_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic [31:0] mem_rd_data;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    kronos_mem_arbiter #(
        .MAX_DATA_BURST (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_data   (instr_data),
        .instr_ack    (instr_ack),
        .instr_err    (instr_err),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_mask    (data_mask),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_rd_data (data_rd_data),
        .data_ack     (data_ack),
        .data_err     (data_err),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_mask     (mem_mask),
        .mem_wr_en    (mem_wr_en),
        .mem_req      (mem_req),
        .mem_rd_data  (mem_rd_data),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs for the new cycle follow
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point in the middle of the current cycle
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [9:0] owners;
        int         n_txn;
        int         wait_cyc;

        rst = 1'b1;
        instr_addr = '0; instr_req = 1'b0;
        data_addr = '0; data_wr_data = '0; data_mask = '0; data_wr_en = 1'b0; data_req = 1'b0;
        mem_rd_data = '0; mem_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_mask",  32'(mem_mask),  32'd0);
        check("rst_acks",      32'({instr_ack, data_ack, instr_err, data_err}), 32'd0);
        tick();
        rst = 1'b0;

        // Fetch only, zero-wait memory
        instr_req = 1'b1; instr_addr = 32'h100;
        smp();
        check("f_idle_req", 32'(mem_req), 32'd0);
        tick();
        mem_ack = 1'b1; mem_rd_data = 32'hDEADBEEF;
        smp();
        check("f_mem_req",   32'(mem_req),   32'd1);
        check("f_mem_mask",  32'(mem_mask),  32'hF);
        check("f_mem_addr",  mem_addr,       32'h100);
        check("f_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("f_ack",       32'(instr_ack), 32'd1);
        check("f_data",      instr_data,     32'hDEADBEEF);
        check("f_err",       32'(instr_err), 32'd0);
        check("f_dack",      32'(data_ack),  32'd0);
        tick();
        instr_req = 1'b0;
        smp();
        // mem_ack still high while idle: must be ignored
        check("f_back_idle", 32'(mem_req),   32'd0);
        check("idle_ack_i",  32'(instr_ack), 32'd0);
        check("idle_ack_d",  32'(data_ack),  32'd0);
        tick();
        mem_ack = 1'b0;
        smp();
        check("idle_no_req", 32'(mem_req), 32'd0);
        tick();

        // Simultaneous requests: store wins, fetch follows
        instr_req = 1'b1; instr_addr = 32'h200;
        data_req = 1'b1; data_wr_en = 1'b1; data_addr = 32'h2000;
        data_wr_data = 32'h55AA55AA; data_mask = 4'h3;
        tick();
        mem_ack = 1'b1; mem_rd_data = 32'h0;
        smp();
        check("s_mem_addr",  mem_addr,       32'h2000);
        check("s_mem_wdata", mem_wr_data,    32'h55AA55AA);
        check("s_mem_mask",  32'(mem_mask),  32'h3);
        check("s_mem_wr_en", 32'(mem_wr_en), 32'd1);
        check("s_dack",      32'(data_ack),  32'd1);
        check("s_iack",      32'(instr_ack), 32'd0);
        tick();
        data_req = 1'b0; data_wr_en = 1'b0; mem_ack = 1'b0;
        smp();
        check("s_gap_req", 32'(mem_req), 32'd0);
        tick();
        mem_ack = 1'b1; mem_rd_data = 32'hCAFEF00D;
        smp();
        check("s_f_addr",  mem_addr,       32'h200);
        check("s_f_mask",  32'(mem_mask),  32'hF);
        check("s_f_wr_en", 32'(mem_wr_en), 32'd0);
        check("s_f_ack",   32'(instr_ack), 32'd1);
        check("s_f_data",  instr_data,     32'hCAFEF00D);
        tick();
        instr_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Starvation guard: both held, zero-wait memory
        instr_req = 1'b1; instr_addr = 32'h400;
        data_req = 1'b1; data_wr_en = 1'b0; data_addr = 32'h3000; data_mask = 4'hF;
        mem_ack = 1'b1; mem_rd_data = 32'h1234;
        owners = '0;
        n_txn = 0;
        for (int c = 0; c < 40 && n_txn < 10; c++) begin
            smp();
            if (instr_ack && data_ack) check("st_both_ack", 32'd1, 32'd0);
            if (instr_ack || data_ack) begin
                owners = {owners[8:0], data_ack};
                n_txn++;
            end
            tick();
        end
        instr_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
        check("st_txn_count", 32'(n_txn),  32'd10);
        check("st_pattern",   32'(owners), 32'(10'b1111011110));
        tick();

        // Wait states: ack delayed to the fifth bus cycle
        data_req = 1'b1; data_wr_en = 1'b1; data_addr = 32'h5000;
        data_wr_data = 32'h12345678; data_mask = 4'hC;
        tick();
        data_addr = 32'hFFFF; data_wr_data = 32'hFFFF; data_mask = 4'h1;
        for (int c = 1; c <= 5; c++) begin
            mem_ack = (c == 5);
            smp();
            check($sformatf("w_addr_%0d", c),  mem_addr,       32'h5000);
            check($sformatf("w_wdata_%0d", c), mem_wr_data,    32'h12345678);
            check($sformatf("w_mask_%0d", c),  32'(mem_mask),  32'hC);
            check($sformatf("w_req_%0d", c),   32'(mem_req),   32'd1);
            check($sformatf("w_ack_%0d", c),   32'(data_ack),  32'(c == 5));
            tick();
        end
        data_req = 1'b0; mem_ack = 1'b0;
        smp();
        check("w_done_req", 32'(mem_req), 32'd0);
        tick();

        // Reset mid-transaction
        data_req = 1'b1; data_wr_en = 1'b0; data_addr = 32'h6000; data_mask = 4'hF;
        tick();
        smp();
        check("r_in_data", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1; data_req = 1'b0;
        #1;
        check("r_req_now",  32'(mem_req),  32'd0);
        check("r_addr_now", mem_addr,      32'd0);
        check("r_dack_now", 32'(data_ack), 32'd0);
        tick();
        rst = 1'b0; mem_ack = 1'b1;
        smp();
        check("r_late_dack", 32'(data_ack),  32'd0);
        check("r_late_iack", 32'(instr_ack), 32'd0);
        tick();
        mem_ack = 1'b0;
        smp();
        check("r_idle_req", 32'(mem_req), 32'd0);
        tick();

`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
        // Watchdog: load never acked
        data_req = 1'b1; data_addr = 32'h7000; mem_rd_data = 32'hA5A5A5A5;
        tick();
        wait_cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            smp();
            if (data_ack) begin
                wait_cyc = c;
                check("t_err",   32'(data_err), 32'd1);
                check("t_rdata", data_rd_data,  32'd0);
                break;
            end
            tick();
        end
        check("t_latency", 32'(wait_cyc), 32'(TMO));
        tick();
        data_req = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h800;
        tick();
        mem_ack = 1'b1; mem_rd_data = 32'h600DF00D;
        smp();
        check("t_next_ack",  32'(instr_ack), 32'd1);
        check("t_next_err",  32'(instr_err), 32'd0);
        check("t_next_data", instr_data,     32'h600DF00D);
        tick();
        instr_req = 1'b0; mem_ack = 1'b0;
        tick();
`else
        wait_cyc = 0;
        check("no_tmo_cnt", 32'(wait_cyc + int'(data_err)), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
- Shares a single 32-bit req/ack memory port between the instruction-fetch port and the EX-stage data (load/store) port.
- Instantiated at core top, between the fetch/EX request ports and the external memory bus.
- Data has priority; a burst limit prevents fetch starvation.
- One transaction is outstanding at a time; the grant is held until the memory acks.

Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch is pending before fetch is forced; range 1..15.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- instr_addr  in  32  fetch address, word aligned
- instr_req  in  1  fetch request; held until instr_ack
- instr_data  out  32  fetch read data; valid when instr_ack
- instr_ack  out  1  fetch complete, one-cycle pulse
- instr_err  out  1  fetch aborted by watchdog; qualifies instr_ack
- data_addr  in  32  load/store address
- data_wr_data  in  32  store data
- data_mask  in  4  byte enables
- data_wr_en  in  1  1 = store, 0 = load
- data_req  in  1  data request; held until data_ack
- data_rd_data  out  32  load data; valid when data_ack
- data_ack  out  1  data complete, one-cycle pulse
- data_err  out  1  data aborted by watchdog; qualifies data_ack
- mem_addr  out  32  bus address
- mem_wr_data  out  32  bus store data
- mem_mask  out  4  bus byte enables (4'hF for fetch)
- mem_wr_en  out  1  bus write strobe
- mem_req  out  1  bus request
- mem_rd_data  in  32  bus read data
- mem_ack  in  1  bus acknowledge

Behaviour:
- FSM states: IDLE, INSTR, DATA.
  - rst asserted: state = IDLE, mem_req = 0, mem_wr_en = 0, burst counter = 0. All mem_* address/data/mask registers clear to 0. This takes effect asynchronously, including mid-transaction; the in-flight ack is dropped.
- Grant decision in IDLE, at cycle N:
  - data_req && !(instr_req && burst == MAX_DATA_BURST) -> DATA.
  - else instr_req -> INSTR.
  - else stay in IDLE.
- On grant, the winner's addr/wdata/mask/we are registered at the N edge. mem_req = 1 from cycle N+1.
  - Fetch: mem_mask = 4'hF, mem_wr_en = 0.
- mem_* outputs are held stable while in INSTR/DATA until mem_ack.
- In INSTR/DATA with mem_ack = 1 at cycle K:
  - The owner's ack is driven combinationally in cycle K; the owner's rd_data = mem_rd_data.
  - The non-owner's ack stays 0 and its rd_data is don't-care.
  - mem_req is deasserted; next state = IDLE.
- Minimum request-to-ack latency is 2 cycles (zero-wait memory). Back-to-back throughput is one transaction per 2 cycles.
- A requester's req high in the cycle after its ack is a new request.
- Burst counter:
  - Increments on each DATA grant while instr_req = 1 (saturates at MAX_DATA_BURST).
  - Clears on any INSTR grant, and on any DATA grant when instr_req = 0.
- Simultaneous requests with counter < MAX_DATA_BURST: data wins. With counter == MAX_DATA_BURST: fetch wins.
- A request dropped before grant is a protocol violation; behaviour is undefined and not checked.
- mem_ack while in IDLE is ignored.
- instr_err/data_err are 0 without the optional feature.

Optional Feature:
- Macro: KRONOS_MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter clears on grant and increments each cycle in INSTR/DATA without mem_ack.
  - When it reaches TIMEOUT_CYCLES: owner ack = 1, owner err = 1, rd_data = 32'h0, mem_req drops, state -> IDLE.
  - A late mem_ack arriving in IDLE is ignored.
- Undefined: no counter, err outputs tied 0, and the arbiter waits on mem_ack indefinitely.

Decomposition:
- kronos_types gains:
  - arb_state_e {ARB_IDLE, ARB_INSTR, ARB_DATA}.
  - A constant FETCH_MASK = 4'hF.
- Optional sub-module kronos_mem_arb_timer holds the watchdog counter. Its inputs are clear/enable; its output is expire. It is instantiated only under the macro.

Test Plan:
- Fetch only, zero-wait memory:
  - Stimulus: instr_req at cycle 0, addr 0x100; mem_ack at cycle 1 with data 0xDEADBEEF.
  - Response: mem_req = 1 in cycle 1, mem_mask = F; instr_ack in cycle 1 with instr_data = 0xDEADBEEF; state back to IDLE at cycle 2.
- Simultaneous requests:
  - Stimulus: instr_req and data_req (store 0x55AA55AA to 0x2000, mask 0x3) both at cycle 0.
  - Response: the store is issued first with mem_wr_en = 1 and mem_mask = 3; the fetch is issued after data_ack.
- Starvation, MAX_DATA_BURST = 4:
  - Stimulus: data_req held continuously with instr_req high.
  - Response: exactly 4 data grants, then 1 fetch grant, then the counter is 0.
- Wait states:
  - Stimulus: mem_ack delayed 5 cycles.
  - Response: mem_addr/mem_wr_data/mem_mask are stable throughout and the ack arrives on cycle 5 only.
- Reset mid-transaction:
  - Stimulus: rst pulsed while in DATA.
  - Response: mem_req = 0 in the same cycle; state IDLE; no data_ack; a later mem_ack is ignored.
- With KRONOS_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8:
  - Stimulus: mem_ack is never asserted for a load.
  - Response: data_ack with data_err = 1 and data_rd_data = 0 after 8 cycles; the next request is serviced normally.
